// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: run/set mode controller for a BCD clock; drives the 1 s tick and loads edited time.
module clock_set_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        sw,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic        btn_dec,
    input  logic [23:0] cur_time,
    output logic        tick,
    output logic        load,
    output logic [23:0] ld_time,
    output logic [1:0]  set_field,
    output logic        blink
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_DIV + 1);
    localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
    localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

    typedef enum logic [1:0] {RUN = 2'd0, SET_HH = 2'd1, SET_MM = 2'd2, SET_SS = 2'd3} state_t;

    state_t        state, state_n;
    logic [PW-1:0] presc, presc_n;
    logic [BW-1:0] bc, bc_n;
    logic [23:0]   ed, ed_n;
    logic          blink_n, stay, edit;

    // Invalid BCD or out-of-range fields are treated as 00 before stepping.
    function automatic logic [7:0] adj(input logic [7:0] f, input logic [7:0] mx, input logic up);
        logic [7:0] raw, v, n;
        raw = {4'd0, f[7:4]} * 8'd10 + {4'd0, f[3:0]};
        v = (f[3:0] > 4'd9 || raw > mx) ? 8'd0 : raw;
        n = up ? (v == mx ? 8'd0 : v + 8'd1) : (v == 8'd0 ? mx : v - 8'd1);
        return {4'(n / 8'd10), 4'(n % 8'd10)};
    endfunction

    always_comb begin
        state_n = btn_mode ? state_t'(state + 2'd1) : state;
        presc_n = (state == RUN && state_n == RUN) ? (presc == PMAX ? '0 : presc + PW'(1)) : '0;
        stay    = state_n != RUN && state_n == state;
        bc_n    = stay ? (bc == BMAX ? '0 : bc + BW'(1)) : '0;
        blink_n = stay && (blink ^ (bc == BMAX));
        edit    = state != RUN && !btn_mode && (btn_inc ^ btn_dec);
        ed_n    = ed;
        if (state == RUN && btn_mode)
            ed_n = cur_time;
        else if (edit && state == SET_HH)
            ed_n[23:16] = adj(ed[23:16], 8'd23, btn_inc);
        else if (edit && state == SET_MM)
            ed_n[15:8] = adj(ed[15:8], 8'd59, btn_inc);
        else if (edit && state == SET_SS)
            ed_n[7:0] = adj(ed[7:0], 8'd59, btn_inc);
    end

    always_ff @(posedge clk or negedge sw) begin
        if (!sw) begin
            state <= RUN;
            presc <= '0;
            bc    <= '0;
            blink <= 1'b0;
            tick  <= 1'b0;
            load  <= 1'b0;
            ed    <= '0;
        end else begin
            state <= state_n;
            presc <= presc_n;
            bc    <= bc_n;
            blink <= blink_n;
            tick  <= presc_n == PMAX;
            load  <= state == SET_SS && btn_mode;
            ed    <= ed_n;
        end
    end

    assign set_field = state;
    assign ld_time   = ed;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed and random checks of clock_set_ctrl against a cycle-count model.
module tb_clock_set_ctrl;
    localparam int TD = 4;
    localparam int BD = 2;

    logic        clk = 1'b0;
    logic        sw = 1'b0, btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
    logic [23:0] cur_time = '0;
    logic        tick, load, blink;
    logic [23:0] ld_time;
    logic [1:0]  set_field;

    int   errs = 0, checks = 0;
    bit   run_cmp = 1'b0;
    int   m_mode = 0, m_since = 0;
    bit   m_load = 1'b0;
    logic [23:0] m_ed = '0;
    logic [11:0] tmask, lmask;
    logic [7:0]  bmask, smask;

    clock_set_ctrl #(.TICK_DIV(TD), .BLINK_DIV(BD)) dut (
        .clk(clk), .sw(sw), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
        .cur_time(cur_time), .tick(tick), .load(load), .ld_time(ld_time),
        .set_field(set_field), .blink(blink)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [23:0] a, input logic [23:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, a, e, $time);
        end
    endtask

    function automatic logic [23:0] bump(input logic [23:0] t, input int md, input bit up);
        int sh, lim, v;
        logic [7:0] f;
        logic [23:0] r;
        sh = 8 * (3 - md);
        lim = (md == 1) ? 24 : 60;
        f = 8'(t >> sh);
        v = (f[3:0] < 10 && f[7:4] < 10) ? f[7:4] * 10 + f[3:0] : 0;
        if (v >= lim) v = 0;
        v = up ? (v + 1) % lim : (v + lim - 1) % lim;
        r = t & ~(24'hFF << sh);
        r |= 24'((v / 10) * 16 + v % 10) << sh;
        return r;
    endfunction

    // Model: mode index, cycles spent in current mode, and the edit value.
    always @(posedge clk or negedge sw) begin
        if (!sw) begin
            m_mode = 0; m_since = 0; m_ed = '0; m_load = 1'b0;
        end else begin
            m_load = (m_mode == 3) && btn_mode;
            if (btn_mode) begin
                if (m_mode == 0) m_ed = cur_time;
                m_mode = (m_mode + 1) % 4;
                m_since = 0;
            end else begin
                if (m_mode != 0 && btn_inc != btn_dec) m_ed = bump(m_ed, m_mode, btn_inc);
                m_since++;
            end
        end
    end

    always @(negedge clk) if (run_cmp) begin
        chk("tick", {23'd0, tick}, {23'd0, m_mode == 0 && m_since % TD == TD - 1});
        chk("load", {23'd0, load}, {23'd0, m_load});
        chk("set_field", {22'd0, set_field}, {22'd0, 2'(m_mode)});
        chk("blink", {23'd0, blink}, {23'd0, m_mode != 0 && (m_since / BD) % 2 == 1});
        chk("ld_time", ld_time, m_ed);
    end

    task automatic step(input bit m, input bit i, input bit d);
        btn_mode = m; btn_inc = i; btn_dec = d;
        @(negedge clk);
        btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
    endtask

    task automatic tick_window(input string nm);
        for (int k = 0; k < 12; k++) begin
            #1 tmask[k] = tick; lmask[k] = load;
            @(negedge clk);
        end
        chk({nm, "_tick_mask"}, {12'd0, tmask}, 24'h000888);
        chk({nm, "_load_mask"}, {12'd0, lmask}, 24'h0);
    endtask

    initial begin
        @(negedge clk); @(negedge clk);
        run_cmp = 1'b1;
        #1 chk("reset_ld_time", ld_time, 24'h0);
        chk("reset_field", {22'd0, set_field}, 24'h0);
        @(negedge clk);
        sw = 1'b1;
        tick_window("release");

        cur_time = 24'h123050;
        step(1, 0, 0);
        #1 chk("cap_field", {22'd0, set_field}, 24'h1);
        chk("cap_time", ld_time, 24'h123050);
        @(negedge clk);
        step(0, 1, 0); step(0, 1, 0); step(1, 0, 0);
        #1 chk("mm_field", {22'd0, set_field}, 24'h2);
        @(negedge clk);
        step(0, 0, 1); step(1, 0, 0);
        #1 chk("ss_field", {22'd0, set_field}, 24'h3);
        @(negedge clk);
        step(0, 1, 0); step(1, 0, 0);
        #1 chk("load_pulse", {23'd0, load}, 24'h1);
        chk("load_time", ld_time, 24'h142951);
        chk("run_field", {22'd0, set_field}, 24'h0);
        chk("load_no_tick", {23'd0, tick}, 24'h0);
        @(negedge clk);
        #1 chk("load_single", {23'd0, load}, 24'h0);
        chk("held_time", ld_time, 24'h142951);
        @(negedge clk);

        cur_time = 24'h230059;
        step(1, 0, 0); step(0, 1, 0);
        #1 chk("hh_wrap_up", ld_time, 24'h000059);
        @(negedge clk);
        step(1, 0, 0); step(0, 0, 1);
        #1 chk("mm_wrap_dn", ld_time, 24'h005959);
        @(negedge clk);
        step(1, 0, 0); step(0, 1, 0);
        #1 chk("ss_wrap_up", ld_time, 24'h005900);
        @(negedge clk);
        step(1, 0, 0);

        cur_time = 24'h3F1234;
        step(1, 0, 0); step(0, 1, 0);
        #1 chk("bad_hours", ld_time, 24'h011234);
        @(negedge clk);
        step(0, 1, 1);
        #1 chk("inc_dec_both", ld_time, 24'h011234);
        @(negedge clk);
        step(1, 1, 0);
        #1 chk("mode_prio_field", {22'd0, set_field}, 24'h2);
        chk("mode_prio_time", ld_time, 24'h011234);
        #1 sw = 1'b0;
        #1 chk("arst_time", ld_time, 24'h0);
        chk("arst_outs", {19'd0, tick, load, set_field, blink}, 24'h0);
        @(negedge clk); @(negedge clk);
        sw = 1'b1;
        tick_window("after_arst");

        step(1, 0, 0);
        for (int k = 0; k < 8; k++) begin
            #1 bmask[k] = blink; smask[k] = tick;
            @(negedge clk);
        end
        chk("blink_mask", {16'd0, bmask}, 24'h0000CC);
        chk("set_no_tick", {16'd0, smask}, 24'h0);
        step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2 sw = 1'b0;
                @(negedge clk);
                #2 sw = 1'b1;
                @(negedge clk);
            end else begin
                cur_time = 24'($urandom());
                step($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            end
        end
        run_cmp = 1'b0;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
